telemetry_framer: RTL and testbench
===================================

# telemetry_framer

Parametrised N-channel telemetry snapshot and framing engine feeding a byte-wide UART transmitter; the next generation of the fixed-field panel collector. On a trigger it atomically captures all channel words, honouring per-channel busy flags. It then emits one frame: sync header, sequence number, channel payload, stale-flag bytes and checksum, over a valid/ready byte stream. It sits between the panel/encoder inputs and the `uart_if`-class transmitter. It adds periodic self-triggering and overrun accounting that the previous collector lacked.

## Interface
- `NUM_CH`, default 8: number of channels, 1..64.
- `CH_W`, default 11: channel word width, 1..16.
- `PERIOD`, default 50000: periodic-mode trigger interval in clk cycles, ≥ frame length + 2.
- `HDR0` / `HDR1`, default 8'hEB / 8'h90: sync bytes.
- `clk`  in  1  system clock, single domain.
- `rst`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = triggered by `start`; 1 = periodic every `PERIOD` cycles.
- `start`  in  1  single-cycle trigger; used only when mode=0.
- `ch_data`  in  NUM_CH*CH_W  channel i occupies [i*CH_W +: CH_W].
- `ch_busy`  in  NUM_CH  channel i value unstable while high.
- `tx_data`  out  8  frame byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts byte on valid&ready.
- `frame_active`  out  1  high from capture through last byte accepted.
- `frame_done`  out  1  one-cycle pulse after checksum byte accepted.
- `overrun_cnt`  out  8  saturating count of dropped triggers.

## Operation
- Derived constants:
  - BPC = ceil(CH_W/8).
  - FB = ceil(NUM_CH/8).
  - Frame length L = 3 + NUM_CH*BPC + FB + 1. Defaults give 21 bytes.
- Frame byte order:
  - HDR0, HDR1, SEQ.
  - Channels 0..NUM_CH-1. Each channel is sent as BPC bytes, MSB byte first, zero-extended to BPC*8 bits.
  - Flag bytes 0..FB-1. Bit j of flag byte k is the stale flag of channel 8k+j; unused bits are 0.
  - CSUM = 8-bit modulo-256 sum of every byte from SEQ through the last flag byte. Headers are excluded.
- Capture, for each channel i:
  - If ch_busy[i]=0: the snapshot register takes ch_data, and stale[i]=0.
  - If ch_busy[i]=1: the snapshot register holds its previous value, and stale[i]=1.
  - All channels are captured in the same cycle.
- States:
  - IDLE: waits for a trigger, then goes to CAPTURE.
  - CAPTURE: one cycle; goes to HDR.
  - HDR: two bytes; goes to SEQ.
  - SEQ: goes to DATA.
  - DATA: byte index 0..NUM_CH*BPC-1; goes to FLAGS.
  - FLAGS: index 0..FB-1; goes to CSUM.
  - CSUM: goes to IDLE.
  - Every byte state advances only on valid&ready.
- Trigger source:
  - mode=0: a `start` high in IDLE is the trigger.
  - mode=1: the period counter reaching PERIOD-1 is the trigger. The counter then wraps to 0. `start` is ignored.
  - The period counter is held at 0 while mode=0.
- Overrun:
  - A trigger arriving outside IDLE is dropped. `overrun_cnt` increments and saturates at 255.
  - The in-flight frame is not disturbed.
- SEQ increments at `frame_done`, wrapping 255→0. A frame never emits a half-updated SEQ.
- Checksum is accumulated as bytes are accepted, not recomputed.
- Mode change mid-frame: the current frame completes; the new mode applies from IDLE.

## Timing
- `start` sampled high at edge k (in IDLE) gives:
  - CAPTURE during cycle k+1, with the snapshot latched at edge k+1.
  - `tx_valid`=1 with HDR0 from cycle k+2.
- Back-to-back bytes: with `tx_ready` tied high, one byte per cycle. L bytes occupy cycles k+2..k+L+1, and `frame_done` pulses at cycle k+L+2.
- `tx_data` is stable while `tx_valid` is high and `tx_ready` is low. `tx_valid` never drops before acceptance, except on reset.
- `frame_active` rises at cycle k+1 and falls with the `frame_done` cycle.
- Earliest next trigger accepted: the cycle after `frame_done`, when the state is IDLE.
- Reset values:
  - Outputs: `tx_data`=0, `tx_valid`=0, `frame_active`=0, `frame_done`=0, `overrun_cnt`=0.
  - Internal: SEQ=0, snapshots=0, stale=0, period counter=0, state IDLE.
- Reset asserted mid-frame aborts the frame immediately; no `frame_done` is produced.

## Structure
- Package `telemetry_pkg` holds:
  - The state enum.
  - Default HDR0/HDR1 constants.
  - Functions `bpc(CH_W)` and `flag_bytes(NUM_CH)`.
- Sub-module `telemetry_byte_sel` is combinational. It selects the payload byte from the snapshot vector by byte index. Keeps the FSM independent of NUM_CH/CH_W.
- The top level holds the FSM, the snapshot/stale registers, the SEQ, period and overrun counters, and the checksum accumulator.

## Test plan
- NUM_CH=2, CH_W=11, ch0=11'h5A3, ch1=11'h00F, no busy, `tx_ready`=1, `start` pulse. Required:
  - Stream EB 90 00 05 A3 00 0F 00 B7.
  - `frame_done` at k+11.
  - Next frame SEQ=01.
- Same setup, then second frame with ch_busy=2'b01 and ch0 changed to 11'h111. Required:
  - ch0 bytes repeat 05 A3.
  - Flag byte 01.
  - CSUM = 01+05+A3+00+0F+01 = B9.
- Random `tx_ready` stalls of 0–5 cycles. Required:
  - `tx_data` held stable while stalled.
  - Byte sequence identical to the unstalled run.
- mode=1, PERIOD=40, `tx_ready` held low for 100 cycles. Required:
  - Triggers at counter wrap are dropped and `overrun_cnt` increments on each.
  - After release, the frame completes.
- 256 consecutive frames. Required:
  - SEQ wraps FF→00.
  - `overrun_cnt` saturates at 255 under a 300-overrun stimulus.
- Reset pulse at byte 5 of a frame. Required:
  - `tx_valid` and `frame_active` low asynchronously.
  - No `frame_done`.
  - Next frame starts with SEQ=00.

Source files
------------

// File: rtl/telemetry_pkg.sv
// Shared types and sizing helpers for the telemetry snapshot/framing engine.
package telemetry_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_HDR     = 3'd2,
        ST_SEQ     = 3'd3,
        ST_DATA    = 3'd4,
        ST_FLAGS   = 3'd5,
        ST_CSUM    = 3'd6
    } tf_state_e;

    localparam logic [7:0] DEF_HDR0 = 8'hEB;
    localparam logic [7:0] DEF_HDR1 = 8'h90;

    // Byte index width; 64 channels of 2 bytes each is the largest payload.
    localparam int IDX_W = 8;

    function automatic int bpc(input int ch_w);
        return (ch_w + 7) / 8;
    endfunction

    function automatic int flag_bytes(input int num_ch);
        return (num_ch + 7) / 8;
    endfunction

endpackage

// File: rtl/telemetry_byte_sel.sv
// Combinational payload/flag byte selector; hides NUM_CH/CH_W layout from the FSM.
module telemetry_byte_sel
    import telemetry_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 11
) (
    input  logic [NUM_CH*CH_W-1:0] snap,
    input  logic [NUM_CH-1:0]      stale,
    input  logic [IDX_W-1:0]       data_idx,
    input  logic [IDX_W-1:0]       flag_idx,
    output logic [7:0]             data_byte,
    output logic [7:0]             flag_byte
);

    localparam int BPC = bpc(CH_W);
    localparam int FB  = flag_bytes(NUM_CH);

    logic [BPC*8-1:0] word_pad_s;
    logic [FB*8-1:0]  flag_pad_s;

    // Payload byte: channels in order, each zero-extended and sent MSB byte first.
    always_comb begin
        data_byte  = 8'h00;
        word_pad_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            word_pad_s             = '0;
            word_pad_s[CH_W-1:0]   = snap[c*CH_W +: CH_W];
            for (int m = 0; m < BPC; m++) begin
                data_byte = data_byte |
                    ((data_idx == IDX_W'(c * BPC + m)) ? word_pad_s[(BPC-1-m)*8 +: 8] : 8'h00);
            end
        end
    end

    // Flag byte k carries stale bits of channels 8k..8k+7, unused bits zero.
    always_comb begin
        flag_pad_s             = '0;
        flag_pad_s[NUM_CH-1:0] = stale;
        flag_byte              = 8'h00;
        for (int k = 0; k < FB; k++) begin
            flag_byte = flag_byte |
                ((flag_idx == IDX_W'(k)) ? flag_pad_s[k*8 +: 8] : 8'h00);
        end
    end

endmodule

// File: rtl/telemetry_framer.sv
// N-channel snapshot and framing engine: captures all channels atomically on a
// trigger and streams HDR0 HDR1 SEQ payload flags CSUM over a valid/ready byte port.
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int         NUM_CH = 8,
    parameter int         CH_W   = 11,
    parameter int         PERIOD = 50000,
    parameter logic [7:0] HDR0   = DEF_HDR0,
    parameter logic [7:0] HDR1   = DEF_HDR1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   start,
    input  logic [NUM_CH*CH_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]      ch_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   frame_active,
    output logic                   frame_done,
    output logic [7:0]             overrun_cnt
);

    localparam int BPC = bpc(CH_W);
    localparam int FB  = flag_bytes(NUM_CH);
    localparam int NB  = NUM_CH * BPC;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(NB - 1);
    localparam logic [IDX_W-1:0] LAST_FLAG = IDX_W'(FB - 1);

    tf_state_e               state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_CH*CH_W-1:0]  snap_q, snap_d;
    logic [NUM_CH-1:0]       stale_q, stale_d;
    logic [7:0]              seq_q, seq_d;
    logic [7:0]              csum_q, csum_d;
    logic [7:0]              over_q, over_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    frame_active_q, frame_active_d;
    logic                    frame_done_q, frame_done_d;
    logic [31:0]             per_q, per_d;

    logic                    accept_s;
    logic                    per_wrap_s;
    logic                    trig_s;
    logic [7:0]              run_sum_s;
    logic [IDX_W-1:0]        sel_data_idx_s;
    logic [IDX_W-1:0]        sel_flag_idx_s;
    logic [7:0]              data_byte_s;
    logic [7:0]              flag_byte_s;

    telemetry_byte_sel #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_byte_sel (
        .snap      (snap_q),
        .stale     (stale_q),
        .data_idx  (sel_data_idx_s),
        .flag_idx  (sel_flag_idx_s),
        .data_byte (data_byte_s),
        .flag_byte (flag_byte_s)
    );

    // Handshake, trigger source and look-ahead byte indices.
    always_comb begin
        accept_s   = tx_valid_q & tx_ready;
        per_wrap_s = mode & (per_q == 32'(PERIOD - 1));
        trig_s     = mode ? per_wrap_s : start;
        run_sum_s  = csum_q + tx_data_q;
        if (state_q == ST_DATA) begin
            sel_data_idx_s = idx_q + IDX_W'(1);
        end else begin
            sel_data_idx_s = '0;
        end
        if (state_q == ST_FLAGS) begin
            sel_flag_idx_s = idx_q + IDX_W'(1);
        end else begin
            sel_flag_idx_s = '0;
        end
    end

    // Period counter (parked at zero in start mode) and saturating overrun count.
    always_comb begin
        if (!mode) begin
            per_d = 32'd0;
        end else if (per_wrap_s) begin
            per_d = 32'd0;
        end else begin
            per_d = per_q + 32'd1;
        end
        if (trig_s && (state_q != ST_IDLE) && (over_q != 8'hFF)) begin
            over_d = over_q + 8'd1;
        end else begin
            over_d = over_q;
        end
    end

    // Frame FSM: tx_data/tx_valid are loaded with the byte of the state being entered.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        snap_d         = snap_q;
        stale_d        = stale_q;
        seq_d          = seq_q;
        csum_d         = csum_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = tx_valid_q;
        frame_active_d = frame_active_q;
        frame_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_s) begin
                    state_d        = ST_CAPTURE;
                    frame_active_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!ch_busy[i]) begin
                        snap_d[i*CH_W +: CH_W] = ch_data[i*CH_W +: CH_W];
                        stale_d[i]             = 1'b0;
                    end else begin
                        stale_d[i] = 1'b1;
                    end
                end
                state_d    = ST_HDR;
                idx_d      = '0;
                csum_d     = 8'h00;
                tx_data_d  = HDR0;
                tx_valid_d = 1'b1;
            end
            ST_HDR: begin
                if (accept_s && (idx_q == '0)) begin
                    idx_d     = IDX_W'(1);
                    tx_data_d = HDR1;
                end else if (accept_s) begin
                    state_d   = ST_SEQ;
                    tx_data_d = seq_q;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_SEQ: begin
                if (accept_s) begin
                    csum_d    = run_sum_s;
                    state_d   = ST_DATA;
                    idx_d     = '0;
                    tx_data_d = data_byte_s;
                end else begin
                    state_d = ST_SEQ;
                end
            end
            ST_DATA: begin
                if (accept_s && (idx_q == LAST_DATA)) begin
                    csum_d    = run_sum_s;
                    state_d   = ST_FLAGS;
                    idx_d     = '0;
                    tx_data_d = flag_byte_s;
                end else if (accept_s) begin
                    csum_d    = run_sum_s;
                    idx_d     = sel_data_idx_s;
                    tx_data_d = data_byte_s;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_FLAGS: begin
                if (accept_s && (idx_q == LAST_FLAG)) begin
                    csum_d    = run_sum_s;
                    state_d   = ST_CSUM;
                    tx_data_d = run_sum_s;
                end else if (accept_s) begin
                    csum_d    = run_sum_s;
                    idx_d     = sel_flag_idx_s;
                    tx_data_d = flag_byte_s;
                end else begin
                    state_d = ST_FLAGS;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    state_d        = ST_IDLE;
                    tx_valid_d     = 1'b0;
                    frame_active_d = 1'b0;
                    frame_done_d   = 1'b1;
                    seq_d          = seq_q + 8'd1;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                tx_valid_d     = 1'b0;
                frame_active_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            snap_q         <= '0;
            stale_q        <= '0;
            seq_q          <= 8'h00;
            csum_q         <= 8'h00;
            over_q         <= 8'h00;
            tx_data_q      <= 8'h00;
            tx_valid_q     <= 1'b0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
            per_q          <= 32'd0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            stale_q        <= stale_d;
            seq_q          <= seq_d;
            csum_q         <= csum_d;
            over_q         <= over_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
            per_q          <= per_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign frame_active = frame_active_q;
    assign frame_done   = frame_done_q;
    assign overrun_cnt  = over_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed + randomized bench for telemetry_framer with a byte-list frame model.
module tb_telemetry_framer;

    localparam int NUM_CH = 2;
    localparam int CH_W   = 11;
    localparam int PERIOD = 40;
    localparam int BPC    = (CH_W + 7) / 8;
    localparam int FB     = (NUM_CH + 7) / 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   mode;
    logic                   start;
    logic [NUM_CH*CH_W-1:0] ch_data;
    logic [NUM_CH-1:0]      ch_busy;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   frame_active;
    logic                   frame_done;
    logic [7:0]             overrun_cnt;

    always #5 clk = ~clk;

    telemetry_framer #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .PERIOD (PERIOD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .start        (start),
        .ch_data      (ch_data),
        .ch_busy      (ch_busy),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .overrun_cnt  (overrun_cnt)
    );

    int         pass_cnt  = 0;
    int         check_cnt = 0;
    int         seq_m     = 0;
    int         over_m    = 0;
    int         done_at   = 0;
    int         snap_m [NUM_CH];
    bit         stale_m[NUM_CH];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    task automatic check_ok(input string tag, input logic [31:0] obs, input logic [31:0] want,
                            output bit ok);
        check_cnt++;
        assert (obs === want) begin
            pass_cnt++;
            ok = 1'b1;
        end else begin
            ok = 1'b0;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        bit ok;
        check_ok(tag, obs, want, ok);
    endtask

    task automatic set_ch(input int idx, input int val);
        ch_data[idx*CH_W +: CH_W] = CH_W'(val);
    endtask

    // Snapshot rule: idle channels load, busy channels keep their old value and go stale.
    task automatic model_capture();
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_busy[i]) begin
                snap_m[i]  = int'(ch_data[i*CH_W +: CH_W]);
                stale_m[i] = 1'b0;
            end else begin
                stale_m[i] = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        seq_m = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            snap_m[i]  = 0;
            stale_m[i] = 1'b0;
        end
    endtask

    task automatic model_frame();
        int sum;
        int b;
        int f;
        exp_q.delete();
        exp_q.push_back(8'hEB);
        exp_q.push_back(8'h90);
        exp_q.push_back(8'(seq_m));
        sum = seq_m;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int m = BPC - 1; m >= 0; m--) begin
                b = (snap_m[i] >> (8 * m)) & 255;
                exp_q.push_back(8'(b));
                sum += b;
            end
        end
        for (int k = 0; k < FB; k++) begin
            f = 0;
            for (int j = 0; j < 8; j++) begin
                if ((8 * k + j) < NUM_CH && stale_m[8 * k + j]) f += (1 << j);
            end
            exp_q.push_back(8'(f));
            sum += f;
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic cmp_frame(input string tag);
        bit ok;
        check_ok({tag, "_len"}, got.size(), exp_q.size(), ok);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check_ok($sformatf("%s_b%0d", tag, i), got[i], exp_q[i], ok);
            if (!ok) break;
        end
    endtask

    // Sinks one frame; n counts negedges after the trigger edge, stalls are random 0..stall_max.
    task automatic run_frame(input bit chk_start, input int stall_max, input int hold_cycles,
                             input int budget);
        int         n;
        int         stall_left;
        bit         prev_wait;
        logic [7:0] held;
        got.delete();
        done_at    = 0;
        n          = 0;
        stall_left = 0;
        prev_wait  = 1'b0;
        held       = 8'h00;
        while (done_at == 0 && n < budget) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (chk_start && n == 1) begin
                check("active_at_capture", frame_active, 1);
                check("valid_low_at_capture", tx_valid, 0);
            end
            if (prev_wait) begin
                check("stall_valid_held", tx_valid, 1);
                check("stall_data_held", tx_data, held);
            end
            if (frame_done) begin
                done_at = n;
                check("active_low_at_done", frame_active, 0);
                check("valid_low_at_done", tx_valid, 0);
            end else begin
                if (tx_valid && !prev_wait) stall_left = int'($urandom_range(stall_max, 0));
                if (n <= hold_cycles) begin
                    tx_ready = 1'b0;
                end else if (stall_left > 0) begin
                    tx_ready = 1'b0;
                    stall_left--;
                end else begin
                    tx_ready = 1'b1;
                end
                if (tx_valid && tx_ready) got.push_back(tx_data);
                prev_wait = tx_valid && !tx_ready;
                held      = tx_data;
            end
        end
        if (done_at == 0) check("frame_timeout", 0, 1);
    endtask

    initial begin
        rst      = 1'b0;
        mode     = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b0;
        ch_data  = '0;
        ch_busy  = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_frame_active", frame_active, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun_cnt, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_frame", frame_active, 0);

        // Reference frame from the test plan.
        set_ch(0, 'h5A3);
        set_ch(1, 'h00F);
        ch_busy = 2'b00;
        model_capture();
        start = 1'b1;
        run_frame(1'b1, 0, 0, 40);
        exp_q = '{8'hEB, 8'h90, 8'h00, 8'h05, 8'hA3, 8'h00, 8'h0F, 8'h00, 8'hB7};
        cmp_frame("frame1");
        check("frame1_done_cycle", done_at, 11);
        seq_m = 1;

        // Busy ch0: old snapshot repeats and its stale bit is set.
        @(negedge clk);
        set_ch(0, 'h111);
        ch_busy = 2'b01;
        model_capture();
        start = 1'b1;
        run_frame(1'b1, 0, 0, 40);
        exp_q = '{8'hEB, 8'h90, 8'h01, 8'h05, 8'hA3, 8'h00, 8'h0F, 8'h01, 8'hB9};
        cmp_frame("frame2");
        check("frame2_done_cycle", done_at, 11);
        seq_m = 2;

        // Same data sent unstalled then with random stalls.
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            if (r % 2 == 0) begin
                for (int i = 0; i < NUM_CH; i++) set_ch(i, int'($urandom_range(2047, 0)));
            end
            ch_busy = 2'b00;
            model_capture();
            model_frame();
            start = 1'b1;
            run_frame(1'b1, (r % 2 == 1) ? 5 : 0, 0, 200);
            cmp_frame($sformatf("stall%0d", r));
            seq_m = (seq_m + 1) % 256;
        end

        // Periodic mode with the sink blocked: later wraps are dropped as overruns.
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) set_ch(i, int'($urandom_range(2047, 0)));
        ch_busy = 2'b00;
        model_capture();
        mode     = 1'b1;
        tx_ready = 1'b0;
        run_frame(1'b0, 0, 100, 200);
        mode = 1'b0;
        model_frame();
        cmp_frame("periodic");
        seq_m  = (seq_m + 1) % 256;
        over_m = over_m + (100 / PERIOD) - 1;
        check("overrun_periodic", overrun_cnt, over_m);
        repeat (3 * PERIOD) @(negedge clk);
        check("mode0_no_self_trigger", frame_active, 0);

        // 300 triggers against a stalled frame saturate the overrun counter.
        @(negedge clk);
        model_capture();
        tx_ready = 1'b0;
        start    = 1'b1;
        for (int e = 1; e <= 301; e++) begin
            @(negedge clk);
            if (e == 200) check("overrun_mid", overrun_cnt, (over_m + 199 > 255) ? 255 : over_m + 199);
        end
        start  = 1'b0;
        over_m = (over_m + 300 > 255) ? 255 : over_m + 300;
        check("overrun_saturated", overrun_cnt, over_m);
        run_frame(1'b0, 0, 0, 40);
        model_frame();
        cmp_frame("after_overrun");
        seq_m = (seq_m + 1) % 256;

        // 256 frames so SEQ wraps FF->00.
        for (int f = 0; f < 256; f++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) set_ch(i, int'($urandom_range(2047, 0)));
            ch_busy = NUM_CH'($urandom_range(3, 0));
            model_capture();
            start = 1'b1;
            run_frame(1'b1, 0, 0, 40);
            model_frame();
            cmp_frame($sformatf("seqrun%0d", f));
            seq_m = (seq_m + 1) % 256;
        end

        // Reset while byte 5 is on the bus.
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) set_ch(i, int'($urandom_range(2047, 0)));
        ch_busy  = 2'b00;
        tx_ready = 1'b1;
        start    = 1'b1;
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", tx_valid, 0);
        check("async_rst_active", frame_active, 0);
        check("async_rst_data", tx_data, 0);
        check("async_rst_overrun", overrun_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("no_done_after_rst%0d", c), frame_done, 0);
        end
        model_reset();
        ch_busy = 2'b11;
        model_capture();
        start = 1'b1;
        run_frame(1'b1, 0, 0, 40);
        model_frame();
        cmp_frame("post_reset");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
